// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Widest operand the serial adder is built for.
  localparam int unsigned SERIAL_ADDER_MAX_WIDTH = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared with the ripple-carry datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Textbook sum/majority equations.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands and carry-in are taken over a valid/ready
// handshake, summed LSB first through one fulladder cell with the carry held in a
// flop, and the result returned over a second valid/ready handshake.
// Build option: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One extra bit so WIDTH=1 still yields a legal counter.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 1 || WIDTH > SERIAL_ADDER_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of range 1..32");
  end

  state_e             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               out_valid_q;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   sum_shifted;
  logic               last_bit;

  fulladder u_fulladder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  always_comb begin
    sum_ext     = {fa_sum, sum_sh};
    sum_shifted = sum_ext[WIDTH:1];
    last_bit    = (cnt == CNT_W'(WIDTH - 1));
  end

  // Sequencer plus operand, sum, carry and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_shifted;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      ovf <= carry ^ fa_cout;
    end
  end
`endif

  // Ready is withheld while reset is asserted even though the state is already IDLE.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = out_valid_q;
    sum       = sum_sh;
    cout      = carry;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8, 3 and 1.
// Define SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, cin8 = 1'b0, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  // WIDTH=3 instance
  logic       in_valid3 = 1'b0, in_ready3, out_valid3, cin3 = 1'b0, cout3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  // WIDTH=1 instance
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, cin1 = 1'b0, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf3, ovf1;
`endif

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
    .cin(cin3), .out_valid(out_valid3), .out_ready(1'b1), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // Reference: plain unsigned addition of the operands, 9-bit result.
  function automatic logic [8:0] add_ref(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
    return 9'(int'(x) + int'(y) + int'(c));
  endfunction

  // Reference: signed sum outside the 8-bit two's-complement range.
  function automatic logic ovf_ref(input logic [7:0] x, input logic [7:0] y, input logic c);
    int sx, sy, s;
    sx = x[7] ? int'(x) - 256 : int'(x);
    sy = y[7] ? int'(y) - 256 : int'(y);
    s  = sx + sy + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 operation and reports what the DUT did; checks are in callers.
  task automatic drive_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input int hold, input bit early, output int lat,
                           output logic [7:0] rs, output logic rc, output logic ro,
                           output bit held_ok, output bit idle_ok);
    int guard = 0;
    while (in_ready8 !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
    tick();
    // Keep in_valid high with junk operands: must be ignored outside IDLE.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    if (early) out_ready8 = 1'b1;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    in_valid8 = 1'b0;
    rs = sum8; rc = cout8; ro = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ro = ovf8;
`endif
    held_ok = 1'b1;
    for (int i = 0; i <= hold; i++) begin
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== rs || cout8 !== rc)
        held_ok = 1'b0;
      if (i < hold) tick();
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    idle_ok = (in_ready8 === 1'b1) && (out_valid8 === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b, want 0 0 00 0",
               in_ready8, out_valid8, sum8, cout8);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || in_ready3 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready8/3/1=%b%b%b, want 111",
               in_ready8, in_ready3, in_ready1);
    end
  endtask

  // One directed op with result, latency and handshake checks.
  task automatic test_directed(input string name, input logic [7:0] ta, input logic [7:0] tb,
                               input logic tc, input int hold, input bit early);
    int lat;
    logic [7:0] rs;
    logic rc, ro;
    bit held_ok, idle_ok;
    logic [8:0] exp;
    exp = add_ref(ta, tb, tc);
    drive_op8(ta, tb, tc, hold, early, lat, rs, rc, ro, held_ok, idle_ok);
    checks++;
    if ({rc, rs} !== exp) begin
      failures++;
      $display("FAIL %s_result: cout,sum=%b,%h want %b,%h", name, rc, rs, exp[8], exp[7:0]);
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles want 8", name, lat);
    end
    checks++;
    if (!held_ok || !idle_ok) begin
      failures++;
      $display("FAIL %s_handshake: held_ok=%0d idle_ok=%0d want 1 1", name, held_ok, idle_ok);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ro !== ovf_ref(ta, tb, tc)) begin
      failures++;
      $display("FAIL %s_ovf: got %b want %b", name, ro, ovf_ref(ta, tb, tc));
    end
`endif
  endtask

  task automatic test_back_to_back();
    test_directed("b2b_first", 8'h5A, 8'hA5, 1'b1, 0, 1'b0);
    test_directed("b2b_second", 8'h12, 8'h34, 1'b0, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bit quiet = 1'b1;
    int guard = 0;
    while (in_ready8 !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 || in_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: out_valid=%b sum=%h cout=%b in_ready=%b want 0 00 0 0",
               out_valid8, sum8, cout8, in_ready8);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready: in_ready=%b want 1", in_ready8);
    end
    for (int i = 0; i < 10; i++) begin
      if (out_valid8 !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL mid_reset_no_result: out_valid pulsed after abort, want none");
    end
    test_directed("after_reset", 8'h03, 8'h04, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] ta, tb;
      logic tc;
      bit early;
      ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
      early = ($urandom_range(0, 3) == 0);
      test_directed("random", ta, tb, tc, early ? 0 : int'($urandom_range(0, 3)), early);
    end
  endtask

  task automatic test_exhaustive_w3();
    int bad = 0;
    int lat_bad = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++) begin
          int guard = 0;
          int lat = 0;
          logic [3:0] exp;
          exp = 4'(x + y + c);
          a3 = 3'(x); b3 = 3'(y); cin3 = 1'(c); in_valid3 = 1'b1;
          while (in_ready3 !== 1'b1 && guard < 20) begin
            tick();
            guard++;
          end
          tick();
          in_valid3 = 1'b0;
          a3 = 3'($urandom); b3 = 3'($urandom);
          while (out_valid3 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
          end
          checks++;
          if ({cout3, sum3} !== exp || lat != 3) begin
            failures++;
            bad++;
            if (bad < 5)
              $display("FAIL w3_add %0d+%0d+%0d: cout,sum=%b,%0d lat=%0d want %b,%0d lat=3",
                       x, y, c, cout3, sum3, lat, exp[3], exp[2:0]);
          end
          tick();
        end
  endtask

  task automatic test_exhaustive_w1();
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          int guard = 0;
          int lat = 0;
          logic [1:0] exp;
          exp = 2'(x + y + c);
          a1 = 1'(x); b1 = 1'(y); cin1 = 1'(c); in_valid1 = 1'b1;
          while (in_ready1 !== 1'b1 && guard < 20) begin
            tick();
            guard++;
          end
          tick();
          in_valid1 = 1'b0;
          while (out_valid1 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
          end
          checks++;
          if ({cout1, sum1} !== exp || lat != 1) begin
            failures++;
            $display("FAIL w1_add %0d+%0d+%0d: cout,sum=%b,%b lat=%0d want %b,%b lat=1",
                     x, y, c, cout1, sum1, lat, exp[1], exp[0]);
          end
          tick();
        end
  endtask

  initial begin
    test_reset();
    test_directed("ff_plus_1", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    test_back_to_back();
    test_directed("backpressure", 8'h0F, 8'h01, 1'b0, 5, 1'b0);
    test_directed("early_ready", 8'h80, 8'h80, 1'b1, 0, 1'b1);
    test_mid_reset();
    test_exhaustive_w3();
    test_exhaustive_w1();
`ifdef SERIAL_ADDER_OVF_EN
    test_directed("ovf_pos", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    test_directed("ovf_none", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
